// File: rtl/psum_acc_sched.sv
// psum_acc_sched: multi-pass partial-sum accumulation sequencer.
//
// Each output tile is made of npass input-channel passes over npix pixels.
// Pass 0 writes the incoming psums into the buffer. Middle passes
// read-add-write the buffer. The last pass adds to the buffer and sends the
// sum straight to a single output register instead of writing it back.
//
// Build option: define PSUM_ACC_SAT_EN to make every accumulation saturate
// to the signed DWIDTH range. If it is undefined, the adds wrap. Timing and
// handshakes are the same in both builds.
//
// Handshake: a transfer on either side happens on a rising clk edge where
// valid and ready are both high. in_rdy and out_vld do not depend on their
// own partner's valid. During the last pass, in_rdy also looks at out_rdy,
// so the output register can be refilled in the cycle it drains.
module psum_acc_sched #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 64,
  parameter int AWIDTH = 6,
  parameter int PWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH:0]   cfg_npix,
  input  logic [PWIDTH-1:0] cfg_npass,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DWIDTH-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AWIDTH:0]   ONE_PIX  = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [PWIDTH-1:0] ONE_PASS = {{(PWIDTH-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [AWIDTH:0]   npix_q, npix_d;
  logic [PWIDTH-1:0] npass_q, npass_d;
  logic [AWIDTH-1:0] pix_cnt_q, pix_cnt_d;
  logic [PWIDTH-1:0] pass_cnt_q, pass_cnt_d;
  logic              out_vld_q, out_vld_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;

  logic [DWIDTH-1:0] buf_q [DEPTH];
  logic              buf_we;
  logic [DWIDTH-1:0] buf_wdata;
  logic [DWIDTH-1:0] buf_rdata;
  logic [DWIDTH-1:0] acc_sum;

  logic in_accum;
  logic first_pass;
  logic last_pass;
  logic last_pix;
  logic xfer;

  // Add two signed operands. The result wraps, or saturates when
  // PSUM_ACC_SAT_EN is defined. Overflow means both operands have the same
  // sign and the sum has the other sign.
  function automatic logic [DWIDTH-1:0] acc_add(input logic [DWIDTH-1:0] a,
                                                input logic [DWIDTH-1:0] b);
    logic [DWIDTH-1:0] s;
    s = a + b;
`ifdef PSUM_ACC_SAT_EN
    if ((a[DWIDTH-1] == b[DWIDTH-1]) && (s[DWIDTH-1] != a[DWIDTH-1])) begin
      s = a[DWIDTH-1] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
    end
`endif
    return s;
  endfunction

  // Decode the pass and pixel position, and form the handshake.
  always_comb begin
    in_accum   = (state_q == S_ACCUM);
    first_pass = (pass_cnt_q == '0);
    last_pass  = (pass_cnt_q == (npass_q - ONE_PASS));
    last_pix   = ({1'b0, pix_cnt_q} == (npix_q - ONE_PIX));
    in_rdy     = in_accum && (!last_pass || !out_vld_q || out_rdy);
    xfer       = in_vld && in_rdy;
    buf_rdata  = buf_q[pix_cnt_q];
    acc_sum    = acc_add(buf_rdata, in_data);
  end

  // Next-state logic: FSM, counters, buffer write and output register load.
  always_comb begin
    state_d    = state_q;
    npix_d     = npix_q;
    npass_d    = npass_q;
    pix_cnt_d  = pix_cnt_q;
    pass_cnt_d = pass_cnt_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    buf_we     = 1'b0;
    buf_wdata  = acc_sum;

    // A drain clears the register. A load in the same cycle, done below,
    // sets it again.
    if (out_vld_q && out_rdy) begin
      out_vld_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // A zero config value is illegal. It is run as 1.
          npix_d     = (cfg_npix == '0) ? ONE_PIX : cfg_npix;
          npass_d    = (cfg_npass == '0) ? ONE_PASS : cfg_npass;
          pix_cnt_d  = '0;
          pass_cnt_d = '0;
          state_d    = S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (xfer) begin
          if (last_pass) begin
            // If there is only one pass, the buffer is never read.
            out_vld_d  = 1'b1;
            out_data_d = first_pass ? in_data : acc_sum;
          end else begin
            buf_we    = 1'b1;
            buf_wdata = first_pass ? in_data : acc_sum;
          end

          if (last_pix) begin
            pix_cnt_d = '0;
            if (last_pass) begin
              state_d = S_DRAIN;
            end else begin
              pass_cnt_d = pass_cnt_q + ONE_PASS;
            end
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end

      S_DRAIN: begin
        if (!out_vld_q || out_rdy) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers, with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      npix_q     <= ONE_PIX;
      npass_q    <= ONE_PASS;
      pix_cnt_q  <= '0;
      pass_cnt_q <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      npix_q     <= npix_d;
      npass_q    <= npass_d;
      pix_cnt_q  <= pix_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  // Accumulation buffer. It has no reset: pass 0 always overwrites an
  // entry before the entry is read.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[pix_cnt_q] <= buf_wdata;
    end
  end

  assign out_vld   = out_vld_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_psum_acc_sched.sv
// tb_psum_acc_sched: directed and randomized tiles for psum_acc_sched.
// The expected results come from a longint model of each pixel's sum
// across passes.
module tb_psum_acc_sched;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int PW = 8;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   cfg_npix;
  logic [PW-1:0] cfg_npass;
  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] in_data;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  psum_acc_sched #(.DWIDTH(DW), .DEPTH(64), .AWIDTH(AW), .PWIDTH(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_npix(cfg_npix), .cfg_npass(cfg_npass),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            n_vec = 0;
  int            n_err = 0;
  int            done_cnt = 0;
  int            rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] stim [8][64];

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference add: exact signed sum, then wrap or clamp.
  function automatic logic [DW-1:0] model_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef PSUM_ACC_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[DW-1:0];
  endfunction

  // Queue the expected output for every pixel of the tile.
  task automatic model_tile(input int np, input int nq);
    logic [DW-1:0] acc;
    for (int p = 0; p < np; p++) begin
      acc = stim[0][p];
      for (int k = 1; k < nq; k++) acc = model_add(acc, stim[k][p]);
      exp_q.push_back(acc);
    end
  endtask

  // ---------------- out_rdy driver ----------------
  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = 1'($urandom_range(0, 1));
        default: out_rdy = 1'b0;
      endcase
    end
  end

  // ---------------- compare process ----------------
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_vld", DW'(out_vld), 1);
          check("hold_data", out_data, prev_data);
        end
        if (out_vld && out_rdy) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_out: got %h expected none", out_data);
          end else begin
            check("out_data", out_data, exp_q.pop_front());
          end
          got_q.push_back(out_data);
        end
        if (done) done_cnt++;
        prev_hold = out_vld && !out_rdy;
        prev_data = out_data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1 while the DUT is idle.
  task automatic start_tile(input int raw_npix, input int raw_npass);
    int np;
    int nq;
    np = (raw_npix == 0) ? 1 : raw_npix;
    nq = (raw_npass == 0) ? 1 : raw_npass;
    model_tile(np, nq);
    got_q.delete();
    done_cnt  = 0;
    cfg_npix  = raw_npix[AW:0];
    cfg_npass = raw_npass[PW-1:0];
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one sample and hold it until it transfers. waited counts the
  // cycles that in_rdy was low.
  task automatic send(input logic [DW-1:0] d, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    in_vld = 1'b1;
    in_data = d;
    while (!ok && waited < 300) begin
      @(negedge clk);
      ok = in_rdy;
      @(posedge clk); #1;
      if (!ok) waited++;
    end
    in_vld = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got no in_rdy expected accept of %h", d);
    end
  endtask

  task automatic feed(input int np, input int nq, input bit gaps);
    int w;
    for (int k = 0; k < nq; k++)
      for (int p = 0; p < np; p++) begin
        send(stim[k][p], w);
        if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      end
  endtask

  task automatic finish_tile(input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_done_timeout: got no done expected done pulse", name);
    end
    @(negedge clk);
    @(negedge clk);
    check({name, "_done_once"}, DW'(done_cnt), 1);
    check({name, "_busy_low"}, DW'(busy), 0);
    check({name, "_exp_empty"}, DW'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int np;
    int nq;
    rst = 1'b1; start = 1'b0; cfg_npix = '0; cfg_npass = '0;
    in_vld = 1'b0; in_data = '0;
    #12;
    check("rst_in_rdy", DW'(in_rdy), 0);
    check("rst_out_vld", DW'(out_vld), 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", DW'(busy), 0);
    check("rst_done", DW'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single pass. Each result appears one cycle after it is accepted.
    rdy_mode = 0;
    for (int p = 0; p < 4; p++) stim[0][p] = DW'(p + 1);
    start_tile(4, 1);
    check("t1_busy", DW'(busy), 1);
    for (int p = 0; p < 4; p++) begin
      send(stim[0][p], w);
      @(negedge clk);
      check("t1_lat_vld", DW'(out_vld), 1);
      check("t1_lat_data", out_data, DW'(p + 1));
      @(posedge clk); #1;
    end
    finish_tile("t1");
    for (int p = 0; p < 4; p++) check("t1_lit", got_q[p], DW'(p + 1));

    // Three passes at full throughput.
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 3; p++) stim[k][p] = DW'(10 * k + p);
    start_tile(3, 3);
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 3; p++) begin
        send(stim[k][p], w);
        check("t2_no_stall", DW'(w), 0);
      end
    finish_tile("t2");
    check("t2_lit0", got_q[0], 30);
    check("t2_lit1", got_q[1], 33);
    check("t2_lit2", got_q[2], 36);

    // Backpressure during the last pass.
    rdy_mode = 2;
    @(posedge clk); #1;
    stim[0][0] = 32'd7; stim[0][1] = 32'hFFFF_FFF7;
    stim[1][0] = 32'd7; stim[1][1] = 32'hFFFF_FFF7;
    start_tile(2, 2);
    send(stim[0][0], w);
    send(stim[0][1], w);
    send(stim[1][0], w);
    in_vld = 1'b1;
    in_data = stim[1][1];
    repeat (3) begin
      @(negedge clk);
      check("t3_in_rdy_low", DW'(in_rdy), 0);
      check("t3_out_vld", DW'(out_vld), 1);
      check("t3_out_held", out_data, 32'd14);
    end
    @(posedge clk); #1;
    rdy_mode = 0;
    send(stim[1][1], w);
    finish_tile("t3");
    check("t3_lit0", got_q[0], 32'd14);
    check("t3_lit1", got_q[1], 32'hFFFF_FFEE);

    // Overflow at the positive and negative ends.
    stim[0][0] = 32'h7FFF_FFFF; stim[1][0] = 32'h7FFF_FFFF;
    start_tile(1, 2);
    feed(1, 2, 1'b0);
    finish_tile("t4p");
`ifdef PSUM_ACC_SAT_EN
    check("t4_pos_lit", got_q[0], 32'h7FFF_FFFF);
`else
    check("t4_pos_lit", got_q[0], 32'hFFFF_FFFE);
`endif
    stim[0][0] = 32'h8000_0000; stim[1][0] = 32'hFFFF_FFFF;
    start_tile(1, 2);
    feed(1, 2, 1'b0);
    finish_tile("t4n");
`ifdef PSUM_ACC_SAT_EN
    check("t4_neg_lit", got_q[0], 32'h8000_0000);
`else
    check("t4_neg_lit", got_q[0], 32'h7FFF_FFFF);
`endif

    // Reset in the middle of a tile, then a clean tile.
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 4; p++) stim[k][p] = $urandom;
    start_tile(4, 2);
    feed(4, 1, 1'b0);
    send(stim[1][0], w);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_in_rdy", DW'(in_rdy), 0);
    check("t5_rst_out_vld", DW'(out_vld), 0);
    check("t5_rst_out_data", out_data, 0);
    check("t5_rst_busy", DW'(busy), 0);
    check("t5_rst_done", DW'(done), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    stim[0][0] = 32'd5;
    start_tile(1, 1);
    feed(1, 1, 1'b0);
    finish_tile("t5");
    check("t5_lit", got_q[0], 32'd5);

    // A start while busy is ignored.
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) stim[k][p] = $urandom_range(0, 1000);
    start_tile(2, 2);
    send(stim[0][0], w);
    start = 1'b1; cfg_npix = 7'd5; cfg_npass = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    send(stim[0][1], w);
    send(stim[1][0], w);
    send(stim[1][1], w);
    finish_tile("t6");
    check("t6_lit0", got_q[0], stim[0][0] + stim[1][0]);

    // A zero config value runs as 1.
    stim[0][0] = $urandom;
    start_tile(0, 0);
    feed(1, 1, 1'b0);
    finish_tile("t7");
    check("t7_lit", got_q[0], stim[0][0]);

    // Random tiles with random backpressure.
    rdy_mode = 1;
    for (int t = 0; t < 12; t++) begin
      np = (t == 0) ? 64 : $urandom_range(1, 16);
      nq = $urandom_range(1, 4);
      for (int k = 0; k < nq; k++)
        for (int p = 0; p < np; p++) begin
          case ($urandom_range(0, 3))
            0:       stim[k][p] = 32'h7FFF_FFF0 + $urandom_range(0, 15);
            1:       stim[k][p] = 32'h8000_0000 + $urandom_range(0, 15);
            default: stim[k][p] = $urandom;
          endcase
        end
      start_tile(np, nq);
      feed(np, nq, 1'b1);
      finish_tile("rnd");
    end
    rdy_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
